// File: rtl/student_pmod_arbiter.sv
// rtl/student_pmod_arbiter.sv - round-robin ownership arbiter for a shared 16-bit PMOD port
// Four requesters share one pad set; ownership ends on request drop, disable or hold-limit expiry.

module student_pmod_arbiter (
   input  logic        clk_in,
   input  logic        reset_int,
   input  logic        arb_en,
   input  logic [7:0]  hold_limit,
   input  logic [3:0]  req,
   input  logic [63:0] gpo_in,
   input  logic [63:0] oe_in,
   input  logic [15:0] pmod_gpi,
   output logic [3:0]  grant,
   output logic [15:0] pmod_gpo,
   output logic [15:0] pmod_gpio_oe,
   output logic [63:0] gpi_out,
   output logic        busy,
   output logic        timeout_irq
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  grant_q, grant_d;
   logic [1:0]  last_q, last_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic        timeout_q, timeout_d;

   logic [1:0]  rr_idx;
   logic [1:0]  rr_cand;
   logic        rr_found;
   logic        owner_req;
   logic        others_pending;
   logic        limit_hit;

   // Walk downward so the candidate closest after last_q is the one left standing.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = last_q;
      rr_cand  = last_q;
      for (int k = 4; k >= 1; k--) begin
         rr_cand = last_q + 2'(k);
         if (req[rr_cand]) begin
            rr_found = 1'b1;
            rr_idx   = rr_cand;
         end
      end
   end

   assign owner_req      = |(req & grant_q);
   assign others_pending = |(req & ~grant_q);
   assign limit_hit      = (hold_limit != 8'd0) && (hold_cnt_q >= (hold_limit - 8'd1));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE, ST_TURN: begin
            if (arb_en && rr_found) begin
               state_d    = ST_GRANT;
               grant_d    = 4'b0001 << rr_idx;
               last_d     = rr_idx;
               hold_cnt_d = 8'd0;
            end else begin
               state_d = ST_IDLE;
               grant_d = 4'b0000;
            end
         end
         ST_GRANT: begin
            // A voluntary release wins over a simultaneous timeout, so no irq then.
            if (!arb_en || !owner_req) begin
               state_d = ST_TURN;
               grant_d = 4'b0000;
            end else if (limit_hit && others_pending) begin
               state_d   = ST_TURN;
               grant_d   = 4'b0000;
               timeout_d = 1'b1;
            end else if (hold_cnt_q != 8'hFF) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_int) begin
         state_q    <= ST_IDLE;
         grant_q    <= 4'b0000;
         last_q     <= 2'd3;
         hold_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // last_q always names the current owner while grant_q is non-zero.
   always_comb begin
      pmod_gpo     = 16'h0000;
      pmod_gpio_oe = 16'h0000;
      gpi_out      = 64'h0;
      if (grant_q != 4'b0000) begin
         pmod_gpo                     = gpo_in[{last_q, 4'h0} +: 16];
         pmod_gpio_oe                 = oe_in[{last_q, 4'h0} +: 16];
         gpi_out[{last_q, 4'h0} +: 16] = pmod_gpi;
      end
   end

   assign grant       = grant_q;
   assign busy        = (state_q != ST_IDLE);
   assign timeout_irq = timeout_q;

endmodule

// File: tb/tb_student_pmod_arbiter.sv
// tb/tb_student_pmod_arbiter.sv - bench for student_pmod_arbiter
// Owner/turnaround model checked every cycle, plus directed literal expectations.

module tb_student_pmod_arbiter;

   logic        clk_in = 1'b0;
   logic        reset_int;
   logic        arb_en;
   logic [7:0]  hold_limit;
   logic [3:0]  req;
   logic [63:0] gpo_in;
   logic [63:0] oe_in;
   logic [15:0] pmod_gpi;
   logic [3:0]  grant;
   logic [15:0] pmod_gpo;
   logic [15:0] pmod_gpio_oe;
   logic [63:0] gpi_out;
   logic        busy;
   logic        timeout_irq;

   int tests = 0;
   int fails = 0;

   int m_owner = -1;
   bit m_turn  = 1'b0;
   int m_last  = 3;
   int m_cnt   = 0;
   bit m_irq   = 1'b0;
   bit m_valid = 1'b0;

   always #5 clk_in = ~clk_in;

   student_pmod_arbiter dut (
      .clk_in       (clk_in),
      .reset_int    (reset_int),
      .arb_en       (arb_en),
      .hold_limit   (hold_limit),
      .req          (req),
      .gpo_in       (gpo_in),
      .oe_in        (oe_in),
      .pmod_gpi     (pmod_gpi),
      .grant        (grant),
      .pmod_gpo     (pmod_gpo),
      .pmod_gpio_oe (pmod_gpio_oe),
      .gpi_out      (gpi_out),
      .busy         (busy),
      .timeout_irq  (timeout_irq)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #2;
      end
   endtask

   // Model: who owns the bus, whether we are in the one-cycle gap, and how long the owner has held.
   always @(posedge clk_in) begin : model_proc
      int o, l, c, others;
      bit t, irq;
      o = m_owner; t = m_turn; l = m_last; c = m_cnt; irq = 1'b0;
      if (reset_int) begin
         o = -1; t = 1'b0; l = 3; c = 0;
      end else if (m_valid) begin
         if (o >= 0) begin
            others = 0;
            for (int i = 0; i < 4; i++) if (i != o && req[i]) others++;
            if (!arb_en || !req[o]) begin
               o = -1; t = 1'b1;
            end else if (hold_limit != 0 && c + 1 >= int'(hold_limit) && others > 0) begin
               o = -1; t = 1'b1; irq = 1'b1;
            end else begin
               c = (c < 255) ? c + 1 : 255;
            end
         end else begin
            t = 1'b0;
            if (arb_en && req != 4'b0000) begin
               for (int k = 1; k <= 4 && o < 0; k++)
                  if (req[(l + k) % 4]) o = (l + k) % 4;
               l = o; c = 0;
            end
         end
      end
      m_owner <= o;
      m_turn  <= t;
      m_last  <= l;
      m_cnt   <= c;
      m_irq   <= irq;
      if (reset_int) m_valid <= 1'b1;
   end

   always @(negedge clk_in) begin : compare_proc
      logic [3:0]  e_grant;
      logic [15:0] e_gpo, e_oe;
      logic [63:0] e_gpi;
      if (m_valid) begin
         e_grant = 4'b0000; e_gpo = 16'h0; e_oe = 16'h0; e_gpi = 64'h0;
         if (m_owner >= 0) begin
            e_grant = 4'b0001 << m_owner;
            e_gpo   = 16'(gpo_in >> (16 * m_owner));
            e_oe    = 16'(oe_in >> (16 * m_owner));
            e_gpi   = 64'(pmod_gpi) << (16 * m_owner);
         end
         chk("m_grant", grant, e_grant);
         chk("m_pmod_gpo", pmod_gpo, e_gpo);
         chk("m_pmod_oe", pmod_gpio_oe, e_oe);
         chk("m_gpi_out", gpi_out, e_gpi);
         chk("m_busy", busy, (m_owner >= 0 || m_turn) ? 1 : 0);
         chk("m_irq", timeout_irq, m_irq);
      end
   end

   initial begin
      reset_int  = 1'b1;
      arb_en     = 1'b1;
      hold_limit = 8'd0;
      req        = 4'b0000;
      gpo_in     = {16'h4444, 16'h3333, 16'h2222, 16'hA5A5};
      oe_in      = {16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFFFF};
      pmod_gpi   = 16'h1234;
      tick(3);
      chk("rst_grant", grant, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      reset_int = 1'b0;
      tick(2);
      chk("idle_grant", grant, 4'b0000);

      req = 4'b0101;
      tick(1);
      chk("first_grant", grant, 4'b0001);
      chk("first_gpo", pmod_gpo, 16'hA5A5);
      chk("first_oe", pmod_gpio_oe, 16'hFFFF);
      chk("first_gpi", gpi_out, 64'h1234);

      req = 4'b0100;
      tick(1);
      chk("turn_grant", grant, 4'b0000);
      chk("turn_gpo", pmod_gpo, 16'h0000);
      chk("turn_oe", pmod_gpio_oe, 16'h0000);
      chk("turn_busy", busy, 1'b1);
      tick(1);
      chk("after_turn_grant", grant, 4'b0100);
      chk("after_turn_gpo", pmod_gpo, 16'h3333);
      req = 4'b0000;
      tick(2);

      reset_int = 1'b1;
      tick(1);
      reset_int  = 1'b0;
      hold_limit = 8'd4;
      req        = 4'b0011;
      tick(1);
      chk("hl_grant0_c1", grant, 4'b0001);
      for (int i = 2; i <= 4; i++) begin
         tick(1);
         chk("hl_grant0_hold", grant, 4'b0001);
      end
      tick(1);
      chk("hl_turn_grant", grant, 4'b0000);
      chk("hl_irq", timeout_irq, 1'b1);
      tick(1);
      chk("hl_grant1", grant, 4'b0010);
      chk("hl_irq_clear", timeout_irq, 1'b0);
      tick(3);
      chk("hl_grant1_hold", grant, 4'b0010);
      tick(1);
      chk("hl_turn2_irq", timeout_irq, 1'b1);
      tick(1);
      chk("hl_back_to_0", grant, 4'b0001);

      req = 4'b0000;
      tick(2);
      req = 4'b1000;
      tick(1);
      chk("solo_grant", grant, 4'b1000);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("solo_hold", grant, 4'b1000);
         chk("solo_no_irq", timeout_irq, 1'b0);
      end

      req = 4'b0001;
      tick(1);
      chk("rel_vs_to_grant", grant, 4'b0000);
      chk("rel_vs_to_irq", timeout_irq, 1'b0);
      tick(1);
      chk("rel_vs_to_next", grant, 4'b0001);

      hold_limit = 8'd0;
      req        = 4'b1111;
      tick(2);
      arb_en = 1'b0;
      tick(1);
      chk("dis_turn_grant", grant, 4'b0000);
      chk("dis_turn_busy", busy, 1'b1);
      tick(1);
      chk("dis_idle_busy", busy, 1'b0);
      tick(3);
      chk("dis_idle_grant", grant, 4'b0000);
      arb_en = 1'b1;
      tick(1);
      chk("reen_grant", grant, 4'b0010);

      tick(1);
      reset_int = 1'b1;
      tick(1);
      chk("midrst_grant", grant, 4'b0000);
      chk("midrst_gpo", pmod_gpo, 16'h0000);
      chk("midrst_oe", pmod_gpio_oe, 16'h0000);
      chk("midrst_gpi", gpi_out, 64'h0);
      chk("midrst_busy", busy, 1'b0);
      reset_int = 1'b0;
      tick(1);
      chk("postrst_grant", grant, 4'b0001);
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/student_pmod_arbiter.md
STUDENT_PMOD_ARBITER -- requirements
Module: student_pmod_arbiter

Interface
REQ-001 SHALL have a single clock, clk_in; reset is reset_int, synchronous, active-high.
REQ-002 SHALL have port clk_in  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset_int  in  1  synchronous active-high reset.
REQ-004 SHALL have port arb_en  in  1  arbitration enable from subsystem control.
REQ-005 SHALL have port hold_limit  in  8  max GRANT cycles while others wait; 0 = unlimited.
REQ-006 SHALL have port req  in  4  per-requester PMOD ownership request, level-sensitive.
REQ-007 SHALL have port gpo_in  in  64  requester i output data at bits [16i+15:16i].
REQ-008 SHALL have port oe_in  in  64  requester i output enables at bits [16i+15:16i].
REQ-009 SHALL have port pmod_gpi  in  16  shared PMOD pad inputs.
REQ-010 SHALL have port grant  out  4  registered one-hot ownership, all-zero when unowned.
REQ-011 SHALL have port pmod_gpo  out  16  shared PMOD pad output data.
REQ-012 SHALL have port pmod_gpio_oe  out  16  shared PMOD pad output enables.
REQ-013 SHALL have port gpi_out  out  64  pmod_gpi copied to owner's slice, other slices zero.
REQ-014 SHALL have port busy  out  1  high when state is not IDLE.
REQ-015 SHALL have port timeout_irq  out  1  one-cycle pulse on forced release.

Function
REQ-016 SHALL implement states IDLE, GRANT, TURN; state, grant, pointer, counter registered.
REQ-017 SHALL in IDLE and in TURN, if arb_en=1 and req!=0, pick winner by round-robin from (last+1) mod 4 upward, set grant one-hot, enter GRANT.
REQ-018 SHALL in IDLE with no eligible request remain IDLE with grant=0.
REQ-019 SHALL have latency: req sampled at edge k in IDLE -> grant high after edge k; outputs valid same cycle.
REQ-020 SHALL drive pmod_gpo/pmod_gpio_oe combinationally from owner's gpo_in/oe_in slice when grant!=0, else 0.
REQ-021 SHALL update last pointer to winner on every grant.
REQ-022 SHALL in GRANT, when req[owner]=0, clear grant and enter TURN at next edge.
REQ-023 SHALL in GRANT, when arb_en=0, clear grant and enter TURN; TURN with arb_en=0 goes to IDLE.
REQ-024 SHALL count GRANT cycles in 8-bit hold_cnt, cleared on each new grant, saturating at 255.
REQ-025 SHALL force release when hold_limit!=0, hold_cnt>=hold_limit-1 and another req bit is high: clear grant, enter TURN, pulse timeout_irq one cycle.
REQ-026 SHALL keep grant past hold_limit if no other requester is pending; release re-evaluated every cycle.
REQ-027 SHALL make TURN last exactly one cycle with grant=0, pmod_gpo=0, pmod_gpio_oe=0 (bus turnaround).
REQ-028 SHALL let a force-released requester with req still high compete again at lowest priority.
REQ-029 SHALL on simultaneous owner release and timeout condition take release path, no timeout_irq.
REQ-030 SHALL treat hold_limit changes as taking effect on the next cycle's comparison.

Reset
REQ-031 SHALL on reset_int=1 set state IDLE, grant=0, hold_cnt=0, last=3 (requester 0 first), timeout_irq=0, busy=0.
REQ-032 SHALL on reset mid-GRANT drop grant and pad enables to 0 at that edge, no TURN cycle.
REQ-033 SHALL reach all-zero pmod outputs and gpi_out after reset regardless of inputs.

Verification
REQ-034 SHALL cover: reset, req=4'b0101 -> grant=0001 next cycle; gpo_in[15:0]=A5A5, oe=FFFF appear on pads.
REQ-035 SHALL cover: owner 0 drops req, req[2] high -> one TURN cycle (pads 0), then grant=0100.
REQ-036 SHALL cover: hold_limit=4, req=0011 held -> grant 0001 for 4 cycles, timeout_irq pulse, TURN, grant 0010, then 0001.
REQ-037 SHALL cover: hold_limit=4, only req[3] high for 20 cycles -> grant 1000 stays, no timeout_irq.
REQ-038 SHALL cover: arb_en dropped during GRANT -> TURN then IDLE, grant 0 while req=1111.
REQ-039 SHALL cover: reset_int during GRANT -> grant, pads, gpi_out zero after that edge; first later grant goes to requester 0.
